// File: rtl/adder_temp_pkg.sv
// rtl/adder_temp_pkg.sv - shared widths and FSM state encoding for the nibble range adder
package adder_temp_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int N_NIBBLES = 8;
  localparam int IDX_W     = 3;
  localparam int SUM_W     = 8;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_sel.sv
// rtl/nibble_sel.sv - combinational selection of one nibble from a packed word
module nibble_sel
  import adder_temp_pkg::*;
(
  input  logic [N_NIBBLES*NIBBLE_W-1:0] i_word,
  input  logic [IDX_W-1:0]              i_idx,
  output logic [NIBBLE_W-1:0]           o_nibble
);

  // Nibble k lives at bits [4k+3:4k]
  assign o_nibble = i_word[{i_idx, 2'b00} +: NIBBLE_W];

endmodule

// File: rtl/adder_temp_unit.sv
// rtl/adder_temp_unit.sv - sequential nibble range adder; optional done port via ADDER_TEMP_DONE_EN
module adder_temp_unit
  import adder_temp_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_NIBBLES*NIBBLE_W-1:0] Iin,
  input  logic [IDX_W-1:0]              M,
  input  logic [IDX_W-1:0]              m,
  output logic [SUM_W-1:0]              Y
`ifdef ADDER_TEMP_DONE_EN
  ,
  output logic                          done
`endif
);

  state_t                        r_state;
  logic [N_NIBBLES*NIBBLE_W-1:0] r_word;
  logic [IDX_W-1:0]              r_idx;
  logic [IDX_W-1:0]              r_hi;
  logic [SUM_W-1:0]              r_acc;
  logic [IDX_W-1:0]              w_lo;
  logic [IDX_W-1:0]              w_hi;
  logic [NIBBLE_W-1:0]           w_nib;

  // Order the bounds so the walk always runs upward from lo to hi
  assign w_lo = (M < m) ? M : m;
  assign w_hi = (M < m) ? m : M;

  nibble_sel u_nibble_sel (
    .i_word   (r_word),
    .i_idx    (r_idx),
    .o_nibble (w_nib)
  );

  // FSM: capture operands once, accumulate one nibble per cycle, publish and hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD;
      r_word  <= '0;
      r_idx   <= '0;
      r_hi    <= '0;
      r_acc   <= '0;
      Y       <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          r_word  <= Iin;
          r_idx   <= w_lo;
          r_hi    <= w_hi;
          r_acc   <= '0;
          r_state <= ACC;
        end
        ACC: begin
          r_acc <= r_acc + {{(SUM_W-NIBBLE_W){1'b0}}, w_nib};
          // Terminate before incrementing so idx never wraps past the top nibble
          if (r_idx == r_hi) begin
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          Y <= r_acc;
        end
        default: begin
          r_state <= LOAD;
        end
      endcase
    end
  end

`ifdef ADDER_TEMP_DONE_EN
  // Completion flag rises on the same edge that writes Y and holds until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else if (r_state == DONE) begin
      done <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_temp_unit.sv
// tb/tb_adder_temp_unit.sv - scoreboard bench for adder_temp_unit; done checks under ADDER_TEMP_DONE_EN
module tb_adder_temp_unit;

  typedef struct {
    logic [7:0] y;
    int         lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] iin;
  logic [2:0]  bnd_a;
  logic [2:0]  bnd_b;
  logic [7:0]  y;
  logic        done_w;

  exp_t sb[$];
  int   n_checks;
  int   n_pass;

  adder_temp_unit dut (
    .clk  (clk),
    .rst  (rst),
    .Iin  (iin),
    .M    (bnd_a),
    .m    (bnd_b),
    .Y    (y)
`ifdef ADDER_TEMP_DONE_EN
    ,
    .done (done_w)
`endif
  );

`ifndef ADDER_TEMP_DONE_EN
  assign done_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_sum(input logic [31:0] w, input logic [2:0] a, input logic [2:0] b);
    int lo;
    int hi;
    logic [7:0] s;
    lo = (a < b) ? int'(a) : int'(b);
    hi = (a < b) ? int'(b) : int'(a);
    s = 8'd0;
    for (int k = lo; k <= hi; k++) begin
      s = s + {4'd0, w[4*k +: 4]};
    end
    return s;
  endfunction

  task automatic hold_reset(input logic [31:0] w, input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    rst   = 1'b1;
    iin   = w;
    bnd_a = a;
    bnd_b = b;
    repeat (5) @(negedge clk);
    check("rst_y", {24'd0, y}, 32'd0);
`ifdef ADDER_TEMP_DONE_EN
    check("rst_done", {31'd0, done_w}, 32'd0);
`endif
    rst = 1'b0;
  endtask

  task automatic run_case(input string tag, input logic [31:0] w, input logic [2:0] a,
                          input logic [2:0] b, input logic [7:0] exp_y);
    exp_t e;
    exp_t got_e;
    int   span;
    span  = (a > b) ? int'(a - b) : int'(b - a);
    e.y   = exp_y;
    e.lat = span + 3;
    hold_reset(w, a, b);
    sb.push_back(e);
    got_e.y   = 8'd0;
    got_e.lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        iin   = $urandom;
        bnd_a = 3'($urandom_range(0, 7));
        bnd_b = 3'($urandom_range(0, 7));
      end
      if (c == e.lat - 1) begin
        check({tag, "_pre"}, {24'd0, y}, 32'd0);
`ifdef ADDER_TEMP_DONE_EN
        check({tag, "_pre_done"}, {31'd0, done_w}, 32'd0);
`endif
      end
      if (c == e.lat) begin
        if (sb.size() == 0) begin
          check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
          got_e = sb.pop_front();
          check({tag, "_y"}, {24'd0, y}, {24'd0, got_e.y});
`ifdef ADDER_TEMP_DONE_EN
          check({tag, "_done"}, {31'd0, done_w}, 32'd1);
`endif
        end
      end
      if (c == 20) begin
        check({tag, "_hold"}, {24'd0, y}, {24'd0, got_e.y});
      end
    end
  endtask

  initial begin
    logic [31:0] rw;
    logic [2:0]  ra;
    logic [2:0]  rb;
    n_checks = 0;
    n_pass   = 0;
    rst   = 1'b1;
    iin   = 32'h12345678;
    bnd_a = 3'd0;
    bnd_b = 3'd0;

    run_case("eq66",   32'h12345678, 3'd6, 3'd6, 8'd2);
    run_case("eq77",   32'h12345678, 3'd7, 3'd7, 8'd1);
    run_case("r76",    32'h12345678, 3'd7, 3'd6, 8'd3);
    run_case("r60",    32'h12345678, 3'd6, 3'd0, 8'd35);
    run_case("r04",    32'h12345678, 3'd0, 3'd4, 8'd30);
    run_case("r45",    32'h12345678, 3'd4, 3'd5, 8'd7);
    run_case("max",    32'hFFFFFFFF, 3'd7, 3'd0, 8'd120);
    run_case("r10",    32'h12345678, 3'd1, 3'd0, 8'd15);

    hold_reset(32'h12345678, 3'd0, 3'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_y", {24'd0, y}, 32'd0);
    run_case("restart", 32'h12345678, 3'd0, 3'd7, 8'd36);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_clr", {24'd0, y}, 32'd0);
`ifdef ADDER_TEMP_DONE_EN
    check("async_done", {31'd0, done_w}, 32'd0);
`endif

    for (int i = 0; i < 4; i++) begin
      rw = $urandom;
      ra = 3'($urandom_range(0, 7));
      rb = 3'($urandom_range(0, 7));
      run_case("rand", rw, ra, rb, ref_sum(rw, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
